// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word over valid/ready and shifts it out
// one bit per enabled cycle with frame strobes; consecutive words stream without a gap.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;
    logic             consume;
    logic             last;
    logic             accept;

    assign consume    = (state == SHIFT) && shift_en;
    assign last       = consume && (cnt == LAST_CNT);
    assign load_ready = (state == IDLE) || last;
    assign accept     = load_valid && load_ready;

    // The register always moves toward the output end so sout is a fixed tap.
    assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            shreg <= d;
            cnt   <= '0;
        end else if (last) begin
            state <= IDLE;
            shreg <= shifted;
            cnt   <= '0;
        end else if (consume) begin
            shreg <= shifted;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign sout_valid  = (state == SHIFT);
    assign busy        = (state == SHIFT);
    assign frame_start = (state == SHIFT) && (cnt == '0);
    assign frame_end   = (state == SHIFT) && (cnt == LAST_CNT);
    assign sout        = (state != SHIFT) ? 1'b0
                       : ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);

endmodule
